// File: rtl/mul_seq.sv
// Shift-and-add sequencer for ARM MUL/MLA (low WIDTH bits of a*b [+c]).
// Borrows the core's shared adder through add_a/add_b/add_s while in RUN.
module mul_seq #(
  parameter int WIDTH      = 32,
  parameter int EARLY_TERM = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             adder_req,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             adder_req_q, adder_req_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_z_q, flag_z_d;
  logic             last_iter;

  // Last iteration: fixed count reached, or no multiplier bits left above bit 0.
  assign last_iter = (count_q == CW'(WIDTH-1)) ||
                     ((EARLY_TERM != 0) && (mplier_q[WIDTH-1:1] == '0));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    result_d = result_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = accumulate ? c : '0;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (mplier_q[0]) acc_d = add_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (last_iter) begin
          state_d  = DONE;
          result_d = acc_d;
          flag_n_d = acc_d[WIDTH-1];
          flag_z_d = (acc_d == '0);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE);
    adder_req_d = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      adder_req_q <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      adder_req_q <= adder_req_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;
  assign adder_req = adder_req_q;
  // Keep the shared adder quiet whenever the ALU owns it.
  assign add_a     = adder_req_q ? acc_q   : '0;
  assign add_b     = adder_req_q ? mcand_q : '0;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: early-terminating and full-length instances
// share stimulus; each gets its own adder model.
module tb_mul_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, accumulate;
  logic [W-1:0] a, b, c;

  logic         busy1, done1, fn1, fz1, req1;
  logic [W-1:0] res1, aa1, ab1, as1;
  logic         busy0, done0, fn0, fz0, req0;
  logic [W-1:0] res0, aa0, ab0, as0;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign as1 = aa1 + ab1;
  assign as0 = aa0 + ab0;

  mul_seq #(.WIDTH(W), .EARLY_TERM(1)) dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .a(a), .b(b), .c(c), .busy(busy1), .done(done1), .result(res1),
    .flag_n(fn1), .flag_z(fz1), .adder_req(req1), .add_a(aa1), .add_b(ab1),
    .add_s(as1));

  mul_seq #(.WIDTH(W), .EARLY_TERM(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .a(a), .b(b), .c(c), .busy(busy0), .done(done0), .result(res0),
    .flag_n(fn0), .flag_z(fz0), .adder_req(req0), .add_a(aa0), .add_b(ab0),
    .add_s(as0));

  typedef struct {
    logic         acc;
    logic [W-1:0] a, b, c;
    logic [W-1:0] exp_res;
    int           exp_len;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: plain arithmetic, and run length from the multiplier's top set bit.
  function automatic logic [W-1:0] ref_res(input logic acc, input logic [W-1:0] x,
                                           input logic [W-1:0] y, input logic [W-1:0] z);
    logic [2*W-1:0] p;
    p = x * y;
    return p[W-1:0] + (acc ? z : '0);
  endfunction

  function automatic int ref_len(input logic [W-1:0] y);
    int msb = 0;
    for (int i = 0; i < W; i++) if (y[i]) msb = i;
    return msb + 1;
  endfunction

  // Issue one op and watch both instances for a 36-cycle window.
  task automatic run_op(input string tag, input logic acc, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] z,
                        input logic [W-1:0] exp_res, input int exp_len);
    int reqc1 = 0, reqc0 = 0, dc1 = 0, dc0 = 0, dat1 = -1, dat0 = -1, quiet_bad = 0;
    logic [W-1:0] r1 = '0, r0 = '0;
    logic n1 = 0, z1 = 0, n0 = 0, z0 = 0;
    @(negedge clk);
    start = 1'b1; accumulate = acc; a = x; b = y; c = z;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; c = $urandom;
    for (int s = 0; s < 36; s++) begin
      if (req1) reqc1++;
      if (req0) reqc0++;
      if (!req1 && (aa1 != '0 || ab1 != '0)) quiet_bad++;
      if (!req0 && (aa0 != '0 || ab0 != '0)) quiet_bad++;
      if (done1) begin dc1++; if (dat1 < 0) begin dat1 = s; r1 = res1; n1 = fn1; z1 = fz1; end end
      if (done0) begin dc0++; if (dat0 < 0) begin dat0 = s; r0 = res0; n0 = fn0; z0 = fz0; end end
      @(negedge clk);
    end
    check({tag, " result"},       r1, exp_res);
    check({tag, " flag_n"},       W'(n1), W'(exp_res[W-1]));
    check({tag, " flag_z"},       W'(z1), W'(exp_res == '0));
    check({tag, " run cycles"},   W'(reqc1), W'(exp_len));
    check({tag, " done at"},      W'(dat1), W'(exp_len));
    check({tag, " done count"},   W'(dc1), W'(1));
    check({tag, " result ET0"},   r0, exp_res);
    check({tag, " flag_z ET0"},   W'(z0), W'(exp_res == '0));
    check({tag, " flag_n ET0"},   W'(n0), W'(exp_res[W-1]));
    check({tag, " run ET0"},      W'(reqc0), W'(W));
    check({tag, " done at ET0"},  W'(dat0), W'(W));
    check({tag, " done cnt ET0"}, W'(dc0), W'(1));
    check({tag, " adder quiet"},  W'(quiet_bad), W'(0));
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{1'b0, 32'd3,         32'd5,         32'd0,         32'd15,        3};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd2,         32};
    vecs[2] = '{1'b1, 32'h1234_5678, 32'd0,         32'h8000_0000, 32'h8000_0000, 1};
    vecs[3] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0,         32'd0,         17};

    reset = 1'b1; start = 1'b0; accumulate = 1'b0; a = '0; b = '0; c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   W'(busy1 | busy0), '0);
    check("reset done",   W'(done1 | done0), '0);
    check("reset req",    W'(req1 | req0), '0);
    check("reset flags",  W'({fn1, fz1, fn0, fz0}), '0);
    check("reset result", res1 | res0, '0);
    check("reset add",    aa1 | ab1 | aa0 | ab0, '0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++)
      run_op($sformatf("vec%0d", i), vecs[i].acc, vecs[i].a, vecs[i].b, vecs[i].c,
             vecs[i].exp_res, vecs[i].exp_len);

    for (int i = 0; i < 25; i++) begin
      logic         ra;
      logic [W-1:0] rx, ry, rz;
      ra = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom >> $urandom_range(0, 31);
      rz = $urandom;
      run_op($sformatf("rnd%0d", i), ra, rx, ry, rz, ref_res(ra, rx, ry, rz), ref_len(ry));
    end

    // start held high with operands changing every cycle; ops chain through IDLE.
    begin
      logic [W-1:0] av[24], bv[24];
      int           got_at[$], exp_at[$];
      logic [W-1:0] got_r[$], exp_r[$];
      int           k;
      for (int i = 0; i < 24; i++) begin av[i] = W'(i * 7 + 3); bv[i] = W'((i % 5) + 1); end
      k = 0;
      while (k < 24) begin
        if (k + ref_len(bv[k]) < 24) begin
          exp_at.push_back(k + ref_len(bv[k]));
          exp_r.push_back(ref_res(1'b0, av[k], bv[k], '0));
        end
        k = k + ref_len(bv[k]) + 2;
      end
      accumulate = 1'b0;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (i > 0 && done1) begin got_at.push_back(i - 1); got_r.push_back(res1); end
        start = 1'b1; a = av[i]; b = bv[i];
        @(posedge clk);
      end
      @(negedge clk);
      start = 1'b0;
      check("hs done count", W'(got_at.size()), W'(exp_at.size()));
      for (int i = 0; i < exp_at.size() && i < got_at.size(); i++) begin
        check($sformatf("hs%0d at", i), W'(got_at[i]), W'(exp_at[i]));
        check($sformatf("hs%0d result", i), got_r[i], exp_r[i]);
      end
      repeat (40) @(negedge clk);
    end

    // Abort in the third RUN cycle; no done may follow.
    begin
      int dcount = 0;
      @(negedge clk);
      start = 1'b1; accumulate = 1'b0; a = 32'd7; b = 32'hFF;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("pre-abort busy", W'(busy1 & req1), W'(1));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort busy",   W'(busy1 | busy0), '0);
      check("abort done",   W'(done1 | done0), '0);
      check("abort req",    W'(req1 | req0), '0);
      check("abort result", res1 | res0, '0);
      for (int i = 0; i < 12; i++) begin
        if (done1 || done0 || busy1 || busy0) dcount++;
        @(negedge clk);
      end
      check("abort no done", W'(dcount), '0);
      run_op("after abort", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 3);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle sequencer that executes ARM MUL (Rd = Rm*Rs) and MLA (Rd = Rm*Rs + Rn) using shift-and-add.
- Computes only the low 32 bits of the product.
- Owns no adder: it drives the core's shared 32-bit ripple adder through add_a/add_b/add_s, and requests the adder with adder_req.
- Sits beside the ALU in the execute stage; the decoder stalls on busy.

Parameters:
WIDTH, 32, operand/result width; matches shared adder width.
EARLY_TERM, 1, 1 = stop when remaining multiplier bits are zero; 0 = always WIDTH iterations.

Ports:
clk  input  1  core clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request a multiply; accepted only in IDLE
accumulate  input  1  1 = MLA (add c), 0 = MUL; sampled on accept
a  input  WIDTH  multiplicand (Rm); sampled on accept
b  input  WIDTH  multiplier (Rs); sampled on accept
c  input  WIDTH  accumulate operand (Rn); sampled on accept
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse; result/flags valid
result  output  WIDTH  low WIDTH bits of a*b (+c)
flag_n  output  1  result[WIDTH-1]; valid with done
flag_z  output  1  result == 0; valid with done
adder_req  output  1  high in RUN; external mux gives the shared adder to this block
add_a  output  WIDTH  adder operand A = acc in RUN, else 0
add_b  output  WIDTH  adder operand B = mcand in RUN, else 0
add_s  input  WIDTH  combinational sum from shared adder, carry-in 0, carry-out unused

Behaviour:
- Reset (synchronous, active-high; dominates start):
  - state = IDLE.
  - busy, done, adder_req, flag_n, flag_z = 0.
  - result, acc, mcand, mplier, count = 0.
  - Reset during RUN or DONE aborts the operation. No done is produced; the requester must re-issue.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1: mcand <= a, mplier <= b, acc <= accumulate ? c : 0, count <= 0, go to RUN.
  - On start=0: hold.
- RUN (one iteration per cycle):
  - If mplier[0]: acc <= add_s, where add_s = acc + mcand mod 2^WIDTH. Otherwise acc holds.
  - mcand <= mcand << 1, zero-filled. mplier <= mplier >> 1. count <= count + 1.
  - Exit to DONE when count == WIDTH-1, or when EARLY_TERM=1 and mplier[WIDTH-1:1] == 0.
  - In the exit cycle, result <= next acc.
  - RUN length with EARLY_TERM=1 is msb_index(b)+1, minimum 1 (b=0 gives 1 cycle and no add). With EARLY_TERM=0 it is always WIDTH cycles.
- DONE:
  - done = 1 for exactly this cycle; flag_n and flag_z are driven from result.
  - Next state is IDLE unconditionally.
- Latency: accept edge → RUN cycles → done in the following cycle. Start-to-done = RUN length + 1 clocks.
- start is ignored in RUN and DONE. It is not queued, and operand changes there have no effect. A start high in the DONE cycle is also ignored; the next accept is earliest in the first IDLE cycle.
- result holds its value until the exit cycle of the next operation. flag_n/flag_z hold until the next done.
- Arithmetic: all additions are modulo 2^WIDTH. Overflow and carry are discarded; ARM MULS leaves C/V untouched.
- add_a/add_b are 0 whenever adder_req=0, so the adder is quiet when the ALU does not own it.

Test Plan:
1. MUL: accumulate=0, a=3, b=5, EARLY_TERM=1 → adder_req high 3 cycles; done pulses 4 clocks after accept; result=15, flag_n=0, flag_z=0.
2. MLA wrap: a=0xFFFFFFFF, b=0xFFFFFFFF, c=1 → 32 RUN cycles; result=0x00000002; flags N=0, Z=0.
3. Zero multiplier: accumulate=1, b=0, c=0x80000000 → 1 RUN cycle with no add; result=0x80000000, flag_n=1, flag_z=0.
4. Overflow to zero: a=0x00010000, b=0x00010000 → 17 RUN cycles; result=0, flag_z=1. Repeat with EARLY_TERM=0 → 32 RUN cycles, same result.
5. Handshake: hold start=1 with changing operands through RUN and DONE → exactly one done per accepted op; the second op is accepted only in IDLE and uses the operands present at that edge.
6. Reset mid-RUN (a=7, b=0xFF, cycle 3) → next cycle busy=0, done=0, adder_req=0, result=0, no done pulse. Then a=6, b=7 → result=42.
